// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stop levels, stall-vector
// patterns, arbiter and exception state encodings, and the stall priority decode.
package pipe_ctrl_pkg;

    // Stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
    localparam int STALL_W = 6;

    // Per-stage stop level.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall patterns. A stage that stops also stops every stage in front of it.
    localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NO_STOP}};
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = {STALL_W{STOP}};

    // Shared memory bus arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_IF  = 2'd1,
        ARB_GNT_MEM = 2'd2
    } arb_state_t;

    // Exception sequencing states.
    typedef enum logic [1:0] {
        EXC_RUN        = 2'd0,
        EXC_FLUSH_WAIT = 2'd1,
        EXC_FLUSH      = 2'd2
    } exc_state_t;

    // Stall priority: the oldest (highest) stage that needs to hold wins.
    function automatic logic [STALL_W-1:0] stall_decode(
        input logic mem_wait,
        input logic ex_req,
        input logic id_req,
        input logic if_wait
    );
        logic [STALL_W-1:0] s;
        if (mem_wait)
            s = STALL_MEM;
        else if (ex_req)
            s = STALL_EX;
        else if (id_req)
            s = STALL_ID;
        else if (if_wait)
            s = STALL_IF;
        else
            s = STALL_NONE;
        return s;
    endfunction

endpackage

// File: rtl/pipe_bus_arb.sv
// Shared memory bus arbiter between fetch and MEM stage, with a grant-cycle
// watchdog that forcibly releases the bus when bus_ack never arrives.
module pipe_bus_arb
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic if_bus_req,
    input  logic mem_bus_req,
    input  logic bus_ack,
    input  logic hold_off,      // suppress new grants (pipeline is being flushed)
    output logic if_bus_gnt,
    output logic mem_bus_gnt,
    output logic bus_timeout,
    output logic arb_idle,
    output logic xfer_done      // a granted transaction completes this cycle
);

    // Counter value seen in the last permitted grant cycle (counter is 0 in the first).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_t state;
    logic [7:0] grant_cnt;
    logic       busy;

    assign busy      = if_bus_gnt | mem_bus_gnt;
    assign arb_idle  = (state == ARB_IDLE);
    assign xfer_done = busy & bus_ack;

    // Timeout is a Mealy output: an ack arriving in the last allowed cycle
    // completes the transaction normally instead of being reported as a timeout.
    assign bus_timeout = busy & ~bus_ack & (grant_cnt == CNT_LAST);

    // Arbiter state, registered grants and grant-cycle counter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            if_bus_gnt  <= 1'b0;
            mem_bus_gnt <= 1'b0;
            grant_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    grant_cnt <= '0;
                    // bus_ack in IDLE belongs to nobody and is ignored.
                    if (!hold_off && mem_bus_req) begin
                        state       <= ARB_GNT_MEM;
                        mem_bus_gnt <= 1'b1;
                    end else if (!hold_off && if_bus_req) begin
                        state      <= ARB_GNT_IF;
                        if_bus_gnt <= 1'b1;
                    end
                end
                ARB_GNT_IF, ARB_GNT_MEM: begin
                    // Always return through IDLE so transactions are separated.
                    if (bus_ack || bus_timeout) begin
                        state       <= ARB_IDLE;
                        if_bus_gnt  <= 1'b0;
                        mem_bus_gnt <= 1'b0;
                        grant_cnt   <= '0;
                    end else begin
                        grant_cnt <= grant_cnt + 8'd1;
                    end
                end
                default: begin
                    state       <= ARB_IDLE;
                    if_bus_gnt  <= 1'b0;
                    mem_bus_gnt <= 1'b0;
                    grant_cnt   <= '0;
                end
            endcase
        end
    end

    // Grants must never overlap on the shared bus.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        !(if_bus_gnt && mem_bus_gnt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall decode, exception redirect sequencing, and a
// saturating count of PC-stall cycles. Bus arbitration lives in pipe_bus_arb.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               if_bus_req,
    input  logic               mem_bus_req,
    input  logic               bus_ack,
    input  logic               excp_i,
    input  logic [31:0]        excp_handler_i,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               if_bus_gnt,
    output logic               mem_bus_gnt,
    output logic               bus_timeout,
    output logic [31:0]        stall_cnt
);

    exc_state_t  exc_state;
    logic [31:0] handler_q;
    logic        arb_idle;
    logic        xfer_done;
    logic        hold_off;
    logic        if_gnt_live;
    logic        mem_gnt_live;
    logic        if_wait;
    logic        mem_wait;

    // No new bus transaction may start while the pipeline is being flushed.
    assign hold_off = (exc_state == EXC_FLUSH);

    pipe_bus_arb #(
        .TIMEOUT (TIMEOUT)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .if_bus_req  (if_bus_req),
        .mem_bus_req (mem_bus_req),
        .bus_ack     (bus_ack),
        .hold_off    (hold_off),
        .if_bus_gnt  (if_bus_gnt),
        .mem_bus_gnt (mem_bus_gnt),
        .bus_timeout (bus_timeout),
        .arb_idle    (arb_idle),
        .xfer_done   (xfer_done)
    );

    // Under reset the grants are treated as 0 so stall depends on requests only.
    assign if_gnt_live  = if_bus_gnt & ~rst;
    assign mem_gnt_live = mem_bus_gnt & ~rst;

    // A requester keeps waiting until the cycle its granted transaction is acked.
    assign if_wait  = if_bus_req  & ~(if_gnt_live  & bus_ack);
    assign mem_wait = mem_bus_req & ~(mem_gnt_live & bus_ack);

    // Stall vector: exception sequencing overrides the normal priority decode.
    // NOTE: stall gets a full default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        stall = stall_decode(mem_wait, stallreq_ex, stallreq_id, if_wait);
        if (!rst) begin
            if (exc_state == EXC_FLUSH_WAIT)
                stall = STALL_ALL;
            else if (exc_state == EXC_FLUSH)
                stall = STALL_NONE;
        end
    end

    // Exception FSM with registered flush/new_pc and the latched handler address.
    // Entry goes straight to FLUSH when the bus is free or is released this
    // cycle (ack or forced timeout); otherwise the in-flight transaction is
    // drained in FLUSH_WAIT first.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_state <= EXC_RUN;
            handler_q <= '0;
            flush     <= 1'b0;
            new_pc    <= '0;
        end else begin
            flush  <= 1'b0;
            new_pc <= '0;
            case (exc_state)
                EXC_RUN: begin
                    if (excp_i) begin
                        handler_q <= excp_handler_i;
                        if (arb_idle || xfer_done || bus_timeout) begin
                            exc_state <= EXC_FLUSH;
                            flush     <= 1'b1;
                            new_pc    <= excp_handler_i;
                        end else begin
                            exc_state <= EXC_FLUSH_WAIT;
                        end
                    end
                end
                EXC_FLUSH_WAIT: begin
                    if (xfer_done || bus_timeout) begin
                        exc_state <= EXC_FLUSH;
                        flush     <= 1'b1;
                        new_pc    <= handler_q;
                    end
                end
                EXC_FLUSH: begin
                    exc_state <= EXC_RUN;
                end
                default: begin
                    exc_state <= EXC_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall[0] == STOP && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, bus-grant cycles allowed without bus_ack before forced release (8-bit counter).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallreq_id  input  1  ID stage hazard stall request (load-use).
REQ-005 stallreq_ex  input  1  EX stage multi-cycle stall request (mult/div).
REQ-006 if_bus_req  input  1  fetch requests the shared memory bus; held until served.
REQ-007 mem_bus_req  input  1  MEM stage requests the shared memory bus; held until served.
REQ-008 bus_ack  input  1  one-cycle pulse, current bus transaction complete.
REQ-009 excp_i  input  1  exception taken in MEM stage, one-cycle pulse.
REQ-010 excp_handler_i  input  32  handler address, valid with excp_i.
REQ-011 stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-012 flush  output  1  flush all pipeline registers.
REQ-013 new_pc  output  32  redirect target, valid only while flush=1, else 0.
REQ-014 if_bus_gnt / mem_bus_gnt  output  1 each  registered bus grants, mutually exclusive.
REQ-015 bus_timeout  output  1  one-cycle pulse on forced release.
REQ-016 stall_cnt  output  32  count of cycles with stall[0]=1.

Function
REQ-017 Arbiter states IDLE, GNT_IF, GNT_MEM; IDLE with mem_bus_req -> GNT_MEM, else with if_bus_req -> GNT_IF (MEM has priority on tie).
REQ-018 Grant outputs are 1 exactly while in matching GNT state; bus_ack in GNT state -> IDLE next cycle; minimum one IDLE cycle between transactions.
REQ-019 bus_ack while IDLE is ignored.
REQ-020 Grant-cycle counter clears on entering GNT state; reaching TIMEOUT without bus_ack -> IDLE, bus_timeout=1 for that one cycle.
REQ-021 if_wait = if_bus_req & ~(if_bus_gnt & bus_ack); mem_wait = mem_bus_req & ~(mem_bus_gnt & bus_ack).
REQ-022 stall combinational, highest stage wins: mem_wait -> 011111, else stallreq_ex -> 001111, else stallreq_id -> 000111, else if_wait -> 000011, else 000000.
REQ-023 Exception FSM states RUN, FLUSH_WAIT, FLUSH; excp_i ignored outside RUN; excp_handler_i latched on accepted excp_i.
REQ-024 RUN & excp_i: arbiter IDLE or bus_ack this cycle -> FLUSH; otherwise -> FLUSH_WAIT.
REQ-025 FLUSH_WAIT: stall=111111; exit to FLUSH on bus_ack or bus_timeout.
REQ-026 FLUSH lasts exactly one cycle: flush=1, new_pc=latched handler, stall=000000, arbiter grants no new request; then RUN.
REQ-027 stall_cnt increments each cycle stall[0]=1, saturates at FFFFFFFF, never wraps.

Reset
REQ-028 rst=1 at an edge: arbiter IDLE, exception FSM RUN, grants 0, flush 0, new_pc 0, bus_timeout 0, stall_cnt 0, grant counter 0, latched handler 0.
REQ-029 rst mid-transaction drops any grant at that edge; pending exception is discarded.
REQ-030 While rst=1 stall reflects only REQ-022 inputs with grants 0.

Structure
REQ-031 Stop/NoStop, stall-vector patterns, arbiter and exception state encodings belong in defines.v.
REQ-032 Arbiter with timeout counter is sub-module pipe_bus_arb; pipe_ctrl holds stall decode, exception FSM, stall_cnt.

Verification
REQ-033 if_bus_req=1 only, bus_ack on 3rd grant cycle -> stall=000011 until ack cycle, if_bus_gnt drops next cycle.
REQ-034 if_bus_req and mem_bus_req asserted same cycle from IDLE -> mem_bus_gnt first, stall=011111; after ack+IDLE, if_bus_gnt.
REQ-035 stallreq_id=1 and stallreq_ex=1 together, bus idle -> stall=001111; stall_cnt +1 per cycle.
REQ-036 excp_i with handler 0x00000040 while IDLE -> next cycle flush=1, new_pc=0x00000040, stall=0, then flush=0.
REQ-037 excp_i during GNT_MEM, ack 4 cycles later -> stall=111111 during wait, flush one cycle after ack with latched handler.
REQ-038 TIMEOUT=4, grant without ack -> bus_timeout pulse on 4th grant cycle, IDLE next; rst asserted mid-grant -> all outputs 0 next cycle.
